// File: rtl/int_sched_pkg.sv
// int_sched_pkg: shared cause codes, FSM encoding and mcause helper for the interrupt scheduler.
package int_sched_pkg;
    localparam int WORD_WIDTH = 32;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_SERVICE = 2'd3
    } state_e;

    function automatic logic [WORD_WIDTH-1:0] mk_cause(input logic [3:0] code);
        return {1'b1, {(WORD_WIDTH-5){1'b0}}, code};
    endfunction
endpackage

// File: rtl/sii_sync.sv
// sii_sync: two-flop synchronizer for a single asynchronous level.
module sii_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/int_sched.sv
// int_sched: latches CLINT/external interrupts and runs the request/ack/clear/service handshake with the core.
module int_sched
    import int_sched_pkg::*;
#(
    parameter bit EXT_IRQ_SYNC = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  irq_timer,
    input  logic                  irq_software,
    input  logic                  irq_external,
    input  logic                  mstatus_mie,
    input  logic                  mie_meie,
    input  logic                  mie_msie,
    input  logic                  mie_mtie,
    input  logic                  int_ack,
    input  logic                  mret,
    output logic                  int_req,
    output logic [WORD_WIDTH-1:0] int_cause,
    output logic                  mip_meip,
    output logic                  mip_msip,
    output logic                  mip_mtip,
    output logic                  timer_int_clear,
    output logic                  software_int_clear
);
    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [WORD_WIDTH-1:0] cause_q, cause_d;
    logic                  meip_q, msip_q, msip_d, mtip_q, mtip_d;
    logic                  tclr_q, tclr_d, sclr_q, sclr_d;
    logic                  tprev_q, sprev_q;
    logic                  ext_s, take, pend_any, taken_mti, taken_msi;
    logic [3:0]            sel_code;

    if (EXT_IRQ_SYNC) begin : g_sync
        sii_sync u_sync (.clk(clk), .rst_n(rst_n), .d_i(irq_external), .q_o(ext_s));
    end else begin : g_nosync
        assign ext_s = irq_external;
    end

    always_comb begin
        pend_any  = (meip_q & mie_meie) | (msip_q & mie_msie) | (mtip_q & mie_mtie);
        sel_code  = (meip_q & mie_meie) ? CAUSE_MEI : (msip_q & mie_msie) ? CAUSE_MSI : CAUSE_MTI;
        taken_mti = cause_q == mk_cause(CAUSE_MTI);
        taken_msi = cause_q == mk_cause(CAUSE_MSI);
        state_d   = state_q;
        req_d     = req_q;
        cause_d   = cause_q;
        tclr_d    = 1'b0;
        sclr_d    = 1'b0;
        take      = 1'b0;
        case (state_q)
            ST_IDLE: if (mstatus_mie && pend_any) begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                cause_d = mk_cause(sel_code);
            end
            // ack beats a simultaneous global-enable drop
            ST_REQ: if (int_ack) begin
                state_d = ST_CLEAR;
                req_d   = 1'b0;
                take    = 1'b1;
                tclr_d  = taken_mti;
                sclr_d  = taken_msi;
            end else if (!mstatus_mie) begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
            ST_CLEAR:   state_d = ST_SERVICE;
            ST_SERVICE: if (mret) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        mtip_d = (irq_timer & ~tprev_q) | (mtip_q & ~(take & taken_mti));
        msip_d = (irq_software & ~sprev_q) | (msip_q & ~(take & taken_msi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            cause_q <= '0;
            meip_q  <= 1'b0;
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
            tclr_q  <= 1'b0;
            sclr_q  <= 1'b0;
            tprev_q <= 1'b0;
            sprev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cause_q <= cause_d;
            meip_q  <= ext_s;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            tclr_q  <= tclr_d;
            sclr_q  <= sclr_d;
            tprev_q <= irq_timer;
            sprev_q <= irq_software;
        end
    end

    assign int_req            = req_q;
    assign int_cause          = cause_q;
    assign mip_meip           = meip_q;
    assign mip_msip           = msip_q;
    assign mip_mtip           = mtip_q;
    assign timer_int_clear    = tclr_q;
    assign software_int_clear = sclr_q;
endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: directed handshake scenarios for int_sched with the external synchronizer enabled.
module tb_int_sched;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        irq_timer = 1'b0, irq_software = 1'b0, irq_external = 1'b0;
    logic        mstatus_mie = 1'b0, mie_meie = 1'b0, mie_msie = 1'b0, mie_mtie = 1'b0;
    logic        int_ack = 1'b0, mret = 1'b0;
    logic        int_req, mip_meip, mip_msip, mip_mtip, timer_int_clear, software_int_clear;
    logic [31:0] int_cause;
    int          n_vec = 0, n_err = 0;

    int_sched #(.EXT_IRQ_SYNC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .irq_timer(irq_timer), .irq_software(irq_software), .irq_external(irq_external),
        .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
        .int_ack(int_ack), .mret(mret),
        .int_req(int_req), .int_cause(int_cause),
        .mip_meip(mip_meip), .mip_msip(mip_msip), .mip_mtip(mip_mtip),
        .timer_int_clear(timer_int_clear), .software_int_clear(software_int_clear)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic serve();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        step(1);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'd0, int_req}, 32'd0);
        chk({tag, "_cause"}, int_cause, 32'd0);
        chk({tag, "_mip"}, {29'd0, mip_meip, mip_msip, mip_mtip}, 32'd0);
        chk({tag, "_clr"}, {30'd0, timer_int_clear, software_int_clear}, 32'd0);
    endtask

    initial begin
        mstatus_mie = 1'b1; mie_meie = 1'b1; mie_msie = 1'b1; mie_mtie = 1'b1;
        step(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step(1);
        // timer rise: pend after 1 edge, request after 2
        irq_timer = 1'b1;
        step(1);
        chk("t_pend", {31'd0, mip_mtip}, 32'd1);
        chk("t_req_early", {31'd0, int_req}, 32'd0);
        step(1);
        chk("t_req", {31'd0, int_req}, 32'd1);
        chk("t_cause", int_cause, 32'h8000_0007);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("t_clr", {30'd0, timer_int_clear, software_int_clear}, 32'd2);
        chk("t_unpend", {31'd0, mip_mtip}, 32'd0);
        chk("t_req_drop", {31'd0, int_req}, 32'd0);
        step(1);
        chk("t_clr_once", {31'd0, timer_int_clear}, 32'd0);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        // held level must not re-pend
        step(10);
        chk("hold_nopend", {31'd0, mip_mtip}, 32'd0);
        chk("hold_noreq", {31'd0, int_req}, 32'd0);
        irq_timer = 1'b0;
        step(1);
        irq_timer = 1'b1;
        step(1);
        chk("repend", {31'd0, mip_mtip}, 32'd1);
        step(1);
        chk("repend_req", {31'd0, int_req}, 32'd1);
        serve();
        irq_timer = 1'b0;
        step(1);
        // simultaneous software and timer: MSI first
        irq_software = 1'b1; irq_timer = 1'b1;
        step(2);
        chk("both_cause1", int_cause, 32'h8000_0003);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("both_clr1", {30'd0, timer_int_clear, software_int_clear}, 32'd1);
        chk("both_mip1", {30'd0, mip_msip, mip_mtip}, 32'd1);
        step(1);
        chk("both_svc_req", {31'd0, int_req}, 32'd0);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        step(1);
        chk("both_req2", {31'd0, int_req}, 32'd1);
        chk("both_cause2", int_cause, 32'h8000_0007);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("both_clr2", {30'd0, timer_int_clear, software_int_clear}, 32'd2);
        step(1);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        irq_software = 1'b0; irq_timer = 1'b0;
        step(1);
        // external arrives while MTI is requested
        irq_timer = 1'b1;
        step(2);
        chk("ext_mti_req", int_cause, 32'h8000_0007);
        irq_external = 1'b1;
        step(2);
        chk("ext_sync_lat", {31'd0, mip_meip}, 32'd0);
        step(1);
        chk("ext_meip", {31'd0, mip_meip}, 32'd1);
        chk("ext_cause_hold", int_cause, 32'h8000_0007);
        chk("ext_req_hold", {31'd0, int_req}, 32'd1);
        serve();
        step(1);
        chk("mei_req", {31'd0, int_req}, 32'd1);
        chk("mei_cause", int_cause, 32'h8000_000B);
        irq_external = 1'b0;
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("mei_noclr", {30'd0, timer_int_clear, software_int_clear}, 32'd0);
        step(1);
        chk("mei_noclr2", {30'd0, timer_int_clear, software_int_clear}, 32'd0);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        step(2);
        chk("mei_idle", {31'd0, int_req}, 32'd0);
        irq_timer = 1'b0;
        step(1);
        // global enable withdrawn in REQ
        irq_timer = 1'b1;
        step(2);
        chk("mie_req", {31'd0, int_req}, 32'd1);
        mstatus_mie = 1'b0;
        step(1);
        chk("mie_withdraw", {31'd0, int_req}, 32'd0);
        chk("mie_still_pend", {31'd0, mip_mtip}, 32'd1);
        step(2);
        chk("mie_off_idle", {31'd0, int_req}, 32'd0);
        mstatus_mie = 1'b1;
        step(1);
        chk("mie_rereq", {31'd0, int_req}, 32'd1);
        chk("mie_recause", int_cause, 32'h8000_0007);
        serve();
        irq_timer = 1'b0;
        step(1);
        // reset while in CLEAR
        irq_timer = 1'b1;
        step(2);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("rst_pre_clr", {31'd0, timer_int_clear}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        irq_timer = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("rst_noclr", {30'd0, timer_int_clear, software_int_clear}, 32'd0);
        chk("rst_noreq", {31'd0, int_req}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
